// File: rtl/fsm_seq_tx.sv
// Bit-serial stimulus transmitter for the 4-state Moore FSM, carrying the expected output alongside each bit.
// Optional detection counter is built only when FSM_SEQ_TX_DET_CNT_EN is defined; otherwise det_cnt is tied to 0.
module fsm_seq_tx #(
    parameter int NBITS = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             msg_val,
    output logic             msg_rdy,
    input  logic [NBITS-1:0] msg,
    output logic             ser_val,
    output logic             ser_bit,
    output logic             exp_out,
    output logic             done,
    output logic [CW-1:0]    det_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } model_t;

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NBITS - 1);

    ctrl_t            state_reg, state_next;
    model_t           model_reg, model_next;
    logic [NBITS-1:0] shift_reg, shift_next;
    logic [BW-1:0]    idx_reg, idx_next;

    function automatic model_t model_step(input model_t s, input logic b);
        model_t n;
        case (s)
            ST_A:    n = b ? ST_B : ST_A;
            ST_B:    n = b ? ST_B : ST_C;
            ST_C:    n = b ? ST_D : ST_A;
            ST_D:    n = b ? ST_B : ST_C;
            default: n = ST_A;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            model_reg <= ST_A;
            shift_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            model_reg <= model_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        model_next = model_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (msg_val) begin
                    state_next = SEND;
                    shift_next = msg;
                    idx_next   = '0;
                    model_next = ST_A;
                end
            end
            SEND: begin
                // The model consumes the bit on the wire this cycle, so exp_out lags it by one.
                model_next = model_step(model_reg, shift_reg[0]);
                shift_next = shift_reg >> 1;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign msg_rdy = (state_reg == IDLE);
    assign ser_val = (state_reg == SEND);
    assign ser_bit = ser_val & shift_reg[0];
    assign exp_out = (model_reg == ST_D);
    assign done    = (state_reg == DONE);

`ifdef FSM_SEQ_TX_DET_CNT_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] det_cnt_reg, det_cnt_next;

    // D has no self-loop, so every SEND cycle landing in D is a fresh entry.
    always_comb begin
        det_cnt_next = det_cnt_reg;
        if (state_reg == IDLE && msg_val) begin
            det_cnt_next = '0;
        end else if (state_reg == SEND && model_next == ST_D && det_cnt_reg != CNT_MAX) begin
            det_cnt_next = det_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_cnt_reg <= '0;
        end else begin
            det_cnt_reg <= det_cnt_next;
        end
    end

    assign det_cnt = det_cnt_reg;
`else
    assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_seq_tx.sv
// Scoreboard bench for fsm_seq_tx: a table-driven reference model predicts each frame at accept,
// and a negedge monitor checks every presented bit and done pulse against the queued expectations.
module tb_fsm_seq_tx;

    localparam int NBITS = 8;
    localparam int CW    = 4;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             msg_val = 1'b0;
    logic [NBITS-1:0] msg     = '0;
    logic             msg_rdy;
    logic             ser_val;
    logic             ser_bit;
    logic             exp_out;
    logic             done;
    logic [CW-1:0]    det_cnt;

    fsm_seq_tx #(.NBITS(NBITS), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .msg_val (msg_val),
        .msg_rdy (msg_rdy),
        .msg     (msg),
        .ser_val (ser_val),
        .ser_bit (ser_bit),
        .exp_out (exp_out),
        .done    (done),
        .det_cnt (det_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        bit               is_done;
        bit               sb;
        bit               eo;
        int               dc;
        logic [NBITS-1:0] m;
    } exp_t;

    exp_t sb_q[$];
    int   edge_num = 0;
    int   last_acc = -1000;
    int   acc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    // Next-state table indexed [state][input]; states A..D are 0..3, only D outputs 1.
    int nxt [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, req, edge_num);
        end
    endtask

    // Reference: predict the whole frame the moment it is accepted.
    task automatic predict(input logic [NBITS-1:0] m, input int a);
        exp_t e;
        int   s;
        int   c;
        s = 0;
        c = 0;
        for (int i = 0; i < NBITS; i++) begin
            e.cyc = a + i; e.is_done = 1'b0; e.sb = m[i]; e.eo = (s == 3); e.m = m;
`ifdef FSM_SEQ_TX_DET_CNT_EN
            e.dc = c;
`else
            e.dc = 0;
`endif
            sb_q.push_back(e);
            s = nxt[s][m[i]];
            if (s == 3 && c < (1 << CW) - 1) c++;
        end
        e.cyc = a + NBITS; e.is_done = 1'b1; e.sb = 1'b0; e.eo = (s == 3); e.m = m;
`ifdef FSM_SEQ_TX_DET_CNT_EN
        e.dc = c;
`else
        e.dc = 0;
`endif
        sb_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_num++;
            if (!reset) begin
                sb_q.delete();
                last_acc = -1000;
            end else if (msg_val && edge_num >= last_acc + NBITS + 2) begin
                last_acc = edge_num;
                acc_cnt++;
                predict(msg, edge_num);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_msg_rdy", msg_rdy, 1);
                chk("rst_ser_val", ser_val, 0);
                chk("rst_ser_bit", ser_bit, 0);
                chk("rst_done", done, 0);
                chk("rst_exp_out", exp_out, 0);
                chk("rst_det_cnt", det_cnt, 0);
            end else begin
                chk("msg_rdy", msg_rdy, int'(edge_num >= last_acc + NBITS + 1));
                if (!ser_val) chk("ser_bit_idle", ser_bit, 0);
                if (ser_val || done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", int'(ser_val | done), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("cycle", edge_num, e.cyc);
                        chk("done", done, int'(e.is_done));
                        chk("ser_val", ser_val, int'(!e.is_done));
                        chk("ser_bit", ser_bit, int'(e.sb));
                        chk("exp_out", exp_out, int'(e.eo));
                        chk("det_cnt", det_cnt, e.dc);
                        if (e.is_done)
                            $display("frame msg=%02h done_edge=%0d exp_out=%0d det_cnt=%0d",
                                     e.m, edge_num, exp_out, det_cnt);
                    end
                end else if (sb_q.size() > 0 && sb_q[0].cyc <= edge_num) begin
                    chk("missing_output", int'(ser_val | done), 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [NBITS-1:0] m, input bit keep);
        int n;
        bit got;
        @(negedge clk);
        msg_val = 1'b1;
        msg     = m;
        n       = acc_cnt;
        got     = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != n) got = 1'b1;
        end
        @(negedge clk);
        msg = NBITS'($urandom);
        if (!keep) msg_val = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && edge_num >= last_acc + NBITS + 1) break;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;

        send(8'h05, 1'b0); wait_idle();
        send(8'hAD, 1'b0); wait_idle();
        send(8'hFF, 1'b0); wait_idle();

        // msg_val held high: the second frame must start at the first IDLE edge.
        send(8'h05, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();

        // Abort mid-frame while bit 4 is on the wire.
        send(8'hAD, 1'b0);
        for (int t = 0; t < 20 && edge_num < last_acc + 4; t++) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_msg_rdy", msg_rdy, 1);
        chk("abort_ser_val", ser_val, 0);
        chk("abort_exp_out", exp_out, 0);
        chk("abort_det_cnt", det_cnt, 0);
        chk("abort_done", done, 0);
        sb_q.delete();
        msg_val = 1'b1;
        msg     = 8'h05;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(8'h05, 1'b0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            send(NBITS'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);
        msg_val = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
